piso16_serializer: RTL and testbench

PISO16_SERIALIZER -- requirements
Module: piso16_serializer

---
 rtl/piso16_serializer.sv | 86 ++++++++
 tb/tb_piso16_serializer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/piso16_serializer.sv
// Parallel-in/serial-out frame serializer with a valid/ready output handshake.
// Optional macro PISO16_SER_LSW_FIRST_EN emits word 0 first instead of word DEPTH-1.
module piso16_serializer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [DEPTH*WIDTH-1:0]    din_flat,
    output logic                      load_ready,
    output logic signed [WIDTH-1:0]   dout,
    output logic                      dout_valid,
    input  logic                      dout_ready,
    output logic                      dout_last
);

    localparam int CW = $clog2(DEPTH);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t                       state_q, state_d;
    logic [DEPTH-1:0][WIDTH-1:0]  frame_q, frame_d;
    logic [DEPTH-1:0][WIDTH-1:0]  din_words;
    logic [CW-1:0]                cnt_q, cnt_d, cnt_nxt;
    logic [WIDTH-1:0]             dout_q, dout_d;
    logic                         xfer;
    logic                         accept;

    // Maps the transfer count to the frame word emitted at that position.
    function automatic logic [CW-1:0] word_idx(input logic [CW-1:0] n);
`ifdef PISO16_SER_LSW_FIRST_EN
        return n;
`else
        return CW'(DEPTH - 1) - n;
`endif
    endfunction

    assign din_words  = din_flat;
    assign dout_valid = (state_q == SHIFT);
    assign dout_last  = dout_valid && (cnt_q == CW'(DEPTH - 1));
    assign xfer       = dout_valid && dout_ready;
    assign load_ready = (state_q == IDLE) || (xfer && dout_last);
    assign accept     = load && load_ready;
    assign cnt_nxt    = cnt_q + 1'b1;
    assign dout       = $signed(dout_q);

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        if (accept) begin
            frame_d = din_words;
            cnt_d   = '0;
            dout_d  = din_words[word_idx('0)];
            state_d = SHIFT;
        end else if (xfer) begin
            if (dout_last) begin
                // Counter and dout hold so the final word stays visible while idle.
                state_d = IDLE;
            end else begin
                cnt_d  = cnt_nxt;
                dout_d = frame_q[word_idx(cnt_nxt)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            frame_q <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
        end
    end

endmodule

// File: tb/tb_piso16_serializer.sv
// Self-checking bench for piso16_serializer: vector table plus handshake corner sequences
// and a round trip through a 32-tap delay chain model.
module tb_piso16_serializer;

    localparam int W = 16;
    localparam int D = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 load;
    logic [D*W-1:0]       din_flat;
    logic                 load_ready;
    logic signed [W-1:0]  dout;
    logic                 dout_valid;
    logic                 dout_ready;
    logic                 dout_last;

    int n_pass  = 0;
    int n_total = 0;

    logic [W-1:0] taps [D];

    piso16_serializer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .din_flat   (din_flat),
        .load_ready (load_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last)
    );

    always #5 clk = ~clk;

    // Delay chain: newest word enters tap 0, oldest ends at tap D-1.
    always @(posedge clk) begin
        if (dout_valid && dout_ready) begin
            for (int i = D - 1; i > 0; i--) taps[i] <= taps[i-1];
            taps[0] <= $unsigned(dout);
        end
    end

    typedef struct {
        logic         ld;
        logic         rdy;
        logic         v;
        logic [W-1:0] d;
        logic         l;
        logic         lr;
    } vec_t;

    vec_t vt [34];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [D*W-1:0] mk(input logic [W-1:0] base);
        logic [D*W-1:0] f;
        for (int k = 0; k < D; k++) f[k*W +: W] = base + W'(k);
        return f;
    endfunction

    function automatic logic [W-1:0] emitted(input logic [D*W-1:0] f, input int n);
`ifdef PISO16_SER_LSW_FIRST_EN
        return f[n*W +: W];
`else
        return f[(D-1-n)*W +: W];
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [D*W-1:0] fa, fb, fr;

    initial begin
        int  vcount, nx, hold;
        bit  done, fin;

        fa = mk(16'h0100);
        fb = mk(16'h0200);

        vt[0] = '{ld: 1'b1, rdy: 1'b1, v: 1'b0, d: 16'h0000, l: 1'b0, lr: 1'b1};
        for (int i = 1; i <= 32; i++)
            vt[i] = '{ld: 1'b0, rdy: 1'b1, v: 1'b1, d: emitted(fa, i - 1),
                      l: (i == 32), lr: (i == 32)};
        vt[33] = '{ld: 1'b0, rdy: 1'b1, v: 1'b0, d: emitted(fa, 31), l: 1'b0, lr: 1'b1};

        @(negedge clk);
        rst = 1'b1; load = 1'b0; dout_ready = 1'b0; din_flat = '0;
        tick();
        rst = 1'b0;

        // Basic frame with ready held high
        for (int i = 0; i < 34; i++) begin
            load = vt[i].ld; dout_ready = vt[i].rdy; din_flat = fa;
            #1;
            check($sformatf("vec%0d_valid", i), dout_valid, vt[i].v);
            check($sformatf("vec%0d_dout", i), $unsigned(dout), vt[i].d);
            check($sformatf("vec%0d_last", i), dout_last, vt[i].l);
            check($sformatf("vec%0d_load_ready", i), load_ready, vt[i].lr);
            tick();
        end

        // Backpressure on the 3rd-5th valid cycles
        load = 1'b1; din_flat = fa; dout_ready = 1'b1;
        tick();
        load = 1'b0;
        vcount = 0; nx = 0; hold = 0; done = 0;
        for (int c = 0; c < 100 && !done; c++) begin
            if (dout_valid) begin
                vcount++;
                dout_ready = (vcount >= 3 && vcount <= 5) ? 1'b0 : 1'b1;
                #1;
                if (nx < D) check("stall_order", $unsigned(dout), emitted(fa, nx));
                check("stall_last", dout_last, (nx == D - 1));
                if ($unsigned(dout) == emitted(fa, 2)) hold++;
                if (dout_ready) begin
                    if (dout_last) done = 1;
                    nx++;
                end
            end else begin
                dout_ready = 1'b1;
                #1;
            end
            tick();
        end
        check("stall_done", done, 1);
        check("stall_valid_cycles", vcount, 35);
        check("stall_words", nx, D);
        check("stall_hold_011D", hold, 4);
        check("stall_idle_after", dout_valid, 0);

        // Back-to-back frames on the last transfer
        load = 1'b1; din_flat = fa; dout_ready = 1'b1;
        tick();
        load = 1'b0;
        done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (dout_valid && dout_last) begin
                done = 1;
                load = 1'b1; din_flat = fb;
                #1;
                check("b2b_load_ready", load_ready, 1);
            end
            tick();
        end
        check("b2b_reached_last", done, 1);
        load = 1'b0; din_flat = fa;
        #1;
        check("b2b_valid", dout_valid, 1);
        check("b2b_first_word", $unsigned(dout), emitted(fb, 0));
        check("b2b_last", dout_last, 0);
        nx = 0;
        for (int c = 0; c < 40 && dout_valid; c++) begin
            if (nx < D) check("b2b_order", $unsigned(dout), emitted(fb, nx));
            nx++;
            tick();
            #1;
        end
        check("b2b_words", nx, D);

        // Load pulse mid-frame is ignored, din changes meanwhile have no effect
        @(negedge clk);
        load = 1'b1; din_flat = fa; dout_ready = 1'b1;
        tick();
        load = 1'b0; din_flat = fb;
        nx = 0;
        for (int c = 0; c < 40 && dout_valid; c++) begin
            load = (nx == 9);
            #1;
            if (nx == 9) check("midload_load_ready", load_ready, 0);
            if (nx < D) check("midload_order", $unsigned(dout), emitted(fa, nx));
            check("midload_last", dout_last, (nx == D - 1));
            nx++;
            tick();
        end
        load = 1'b0;
        check("midload_words", nx, D);
        check("midload_idle", dout_valid, 0);

        // Reset aborts a frame after 10 transfers
        load = 1'b1; din_flat = fa; dout_ready = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        #1;
        check("abort_pre_dout", $unsigned(dout), emitted(fa, 10));
        rst = 1'b1; load = 1'b1;
        tick();
        rst = 1'b0; load = 1'b0;
        #1;
        check("abort_dout", $unsigned(dout), 0);
        check("abort_valid", dout_valid, 0);
        check("abort_last", dout_last, 0);
        check("abort_load_ready", load_ready, 1);
        hold = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (dout_valid) hold++;
        end
        check("abort_no_words", hold, 0);

        // Round trip through the delay chain under random backpressure
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < D; k++) fr[k*W +: W] = W'($urandom);
            @(negedge clk);
            load = 1'b1; din_flat = fr; dout_ready = 1'b0;
            tick();
            load = 1'b0; din_flat = '0;
            fin = 0;
            for (int c = 0; c < 400 && !fin; c++) begin
                dout_ready = 1'($urandom_range(0, 1));
                #1;
                fin = dout_valid && dout_ready && dout_last;
                tick();
            end
            check($sformatf("rt%0d_done", f), fin, 1);
`ifndef PISO16_SER_LSW_FIRST_EN
            for (int k = 0; k < D; k++)
                check($sformatf("rt%0d_tap%0d", f, k), taps[k], fr[k*W +: W]);
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
